// File: rtl/ssp_pkg.sv
// Shared definitions for the SSP APB initiator.
//   ssp_state_e   : APB initiator FSM states
//   SSP_*         : SSP register word addresses (PADDR[11:2])
//   ssp_cmd_t     : latched command {write, addr, wdata}
//   ssp_cnt_width : wait-counter width for a given timeout limit
package ssp_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_RESP   = 2'd3
   } ssp_state_e;

   localparam logic [9:0] SSP_CR0   = 10'h000;
   localparam logic [9:0] SSP_CR1   = 10'h001;
   localparam logic [9:0] SSP_DR    = 10'h002;
   localparam logic [9:0] SSP_SR    = 10'h003;
   localparam logic [9:0] SSP_CPSR  = 10'h004;
   localparam logic [9:0] SSP_IMSC  = 10'h005;
   localparam logic [9:0] SSP_RIS   = 10'h006;
   localparam logic [9:0] SSP_MIS   = 10'h007;
   localparam logic [9:0] SSP_DMACR = 10'h008;

   typedef struct packed {
      logic        write;
      logic [9:0]  addr;
      logic [15:0] wdata;
   } ssp_cmd_t;

   // clog2(limit + 1), never less than one bit
   function automatic int unsigned ssp_cnt_width(input int unsigned limit);
      int unsigned w;
      w = $clog2(limit + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/ssp_apb_wdog.sv
// Wait-state counter for the APB initiator.
//   clk, rst   : clock, synchronous active-high reset
//   clr_i      : clear count to zero (highest priority)
//   ld_i       : load count from ld_val_i
//   en_i       : increment count by one
//   expired_o  : count has reached LIMIT-1, i.e. this enabled cycle is the
//                LIMIT-th one; always 0 when LIMIT is 0 (timeout disabled)
module ssp_apb_wdog
   import ssp_pkg::*;
#(
   parameter int unsigned LIMIT = 16,
   localparam int unsigned CW   = ssp_cnt_width(LIMIT)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr_i,
   input  logic          ld_i,
   input  logic [CW-1:0] ld_val_i,
   input  logic          en_i,
   output logic          expired_o
);

   localparam int unsigned    TC_INT = (LIMIT > 0) ? (LIMIT - 1) : 0;
   localparam logic [CW-1:0]  TC     = CW'(TC_INT);

   logic [CW-1:0] count_d, count_q;

   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (ld_i) begin
         count_d = ld_val_i;
      end else if (en_i) begin
         count_d = count_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // Expiry is flagged during the cycle whose wait would be the LIMIT-th,
   // so the FSM leaves ACCESS after exactly LIMIT stalled cycles.
   assign expired_o = (LIMIT != 0) && (count_q == TC);

endmodule

// File: rtl/ssp_apb_master.sv
// APB initiator into the SSP register block.
//   PCLK, PRESET          : clock, synchronous active-high reset
//   cmd_valid/cmd_ready   : command handshake; cmd_write/cmd_addr/cmd_wdata
//   rsp_valid/rsp_ready   : response handshake; rsp_rdata/rsp_err
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA : APB request (all registered)
//   PRDATA/PREADY         : APB completion from the slave
//
// state  | meaning
// IDLE   | waiting for a command; cmd_ready high when no response pending
// SETUP  | APB setup phase, PSEL=1 PENABLE=0
// ACCESS | APB access phase, waiting for PREADY or timeout
// RESP   | response presented until rsp_ready
module ssp_apb_master
   import ssp_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        PCLK,
   input  logic        PRESET,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  logic [9:0]  cmd_addr,
   input  logic [15:0] cmd_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [15:0] rsp_rdata,
   output logic        rsp_err,
   output logic        PSEL,
   output logic        PENABLE,
   output logic        PWRITE,
   output logic [9:0]  PADDR,
   output logic [15:0] PWDATA,
   input  logic [15:0] PRDATA,
   input  logic        PREADY
);

   localparam int unsigned CW = ssp_cnt_width(TIMEOUT_CYCLES);

   ssp_state_e  state_d, state_q;
   ssp_cmd_t    cmd_d, cmd_q;
   logic        psel_d, psel_q;
   logic        penable_d, penable_q;
   logic        rsp_valid_d, rsp_valid_q;
   logic [15:0] rsp_rdata_d, rsp_rdata_q;
   logic        rsp_err_d, rsp_err_q;
   logic        wdog_clr, wdog_en, wdog_expired;

   ssp_apb_wdog #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_wdog (
      .clk       (PCLK),
      .rst       (PRESET),
      .clr_i     (wdog_clr),
      .ld_i      (1'b0),
      .ld_val_i  ({CW{1'b0}}),
      .en_i      (wdog_en),
      .expired_o (wdog_expired)
   );

   // Only combinational output; held low during reset.
   assign cmd_ready = (state_q == ST_IDLE) && !rsp_valid_q && !PRESET;

   always_comb begin
      state_d     = state_q;
      cmd_d       = cmd_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      wdog_clr    = 1'b0;
      wdog_en     = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (cmd_valid && cmd_ready) begin
               cmd_d    = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};
               wdog_clr = 1'b1;
               state_d  = ST_SETUP;
            end
         end
         ST_SETUP: begin
            state_d = ST_ACCESS;
         end
         ST_ACCESS: begin
            // PREADY is checked first so a completion on the expiry cycle
            // is reported as a normal transfer.
            if (PREADY) begin
               rsp_rdata_d = cmd_q.write ? 16'h0000 : PRDATA;
               rsp_err_d   = 1'b0;
               state_d     = ST_RESP;
            end else begin
               wdog_en = 1'b1;
               if (wdog_expired) begin
                  rsp_rdata_d = 16'h0000;
                  rsp_err_d   = 1'b1;
                  state_d     = ST_RESP;
               end
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Outputs registered from the next state so they line up with it.
      psel_d      = (state_d == ST_SETUP) || (state_d == ST_ACCESS);
      penable_d   = (state_d == ST_ACCESS);
      rsp_valid_d = (state_d == ST_RESP);
   end

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state_q     <= ST_IDLE;
         cmd_q       <= '0;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= 16'h0000;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cmd_q       <= cmd_d;
         psel_q      <= psel_d;
         penable_q   <= penable_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign PSEL      = psel_q;
   assign PENABLE   = penable_q;
   assign PWRITE    = cmd_q.write;
   assign PADDR     = cmd_q.addr;
   assign PWDATA    = cmd_q.wdata;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_ssp_apb_master.sv
// Directed bench for ssp_apb_master (timeout limit 8).
// Inputs are driven and outputs sampled on the falling edge of PCLK.
module tb_ssp_apb_master;

   logic        PCLK = 1'b0;
   logic        PRESET;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [9:0]  cmd_addr;
   logic [15:0] cmd_wdata;
   logic        rsp_valid, rsp_ready, rsp_err;
   logic [15:0] rsp_rdata;
   logic        PSEL, PENABLE, PWRITE;
   logic [9:0]  PADDR;
   logic [15:0] PWDATA, PRDATA;
   logic        PREADY;

   int checks   = 0;
   int failures = 0;

   always #5 PCLK = ~PCLK;

   ssp_apb_master #(.TIMEOUT_CYCLES(8)) dut (
      .PCLK(PCLK), .PRESET(PRESET),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err),
      .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
      .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY)
   );

   // Stimulus helpers (no checking inside)
   task automatic issue(input logic w, input logic [9:0] a, input logic [15:0] d);
      cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
   endtask

   task automatic consume;
      rsp_ready = 1'b1;
      @(negedge PCLK);
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset;
      PRESET = 1'b1;
      repeat (2) @(negedge PCLK);
      checks++;
      if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err, cmd_ready} !== 48'h0) begin
         failures++;
         $display("FAIL reset_values got=%h exp=000000000000",
                  {PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err, cmd_ready});
      end
      PRESET = 1'b0;
      @(negedge PCLK);
      checks++;
      if (cmd_ready !== 1'b1) begin
         failures++; $display("FAIL reset_release_cmd_ready got=%b exp=1", cmd_ready);
      end
   endtask

   task automatic test_write_zero_wait;
      PREADY = 1'b1; PRDATA = 16'hFFFF;
      issue(1'b1, 10'h000, 16'h00C7);
      checks++;
      if (cmd_ready !== 1'b1) begin
         failures++; $display("FAIL wr_cmd_ready got=%b exp=1", cmd_ready);
      end
      @(negedge PCLK);
      cmd_valid = 1'b0;
      checks++;
      if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA} !== {1'b1, 1'b0, 1'b1, 10'h000, 16'h00C7}) begin
         failures++;
         $display("FAIL wr_setup got=%h exp=%h", {PSEL, PENABLE, PWRITE, PADDR, PWDATA},
                  {1'b1, 1'b0, 1'b1, 10'h000, 16'h00C7});
      end
      @(negedge PCLK);
      checks++;
      if ({PSEL, PENABLE, rsp_valid} !== 3'b110) begin
         failures++; $display("FAIL wr_access got=%b exp=110", {PSEL, PENABLE, rsp_valid});
      end
      @(negedge PCLK);
      checks++;
      if ({rsp_valid, rsp_rdata, rsp_err, PSEL, PENABLE, PWDATA} !== {1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h00C7}) begin
         failures++;
         $display("FAIL wr_resp got=%h exp=%h", {rsp_valid, rsp_rdata, rsp_err, PSEL, PENABLE, PWDATA},
                  {1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h00C7});
      end
      consume;
      checks++;
      if ({rsp_valid, cmd_ready} !== 2'b01) begin
         failures++; $display("FAIL wr_done got=%b exp=01", {rsp_valid, cmd_ready});
      end
   endtask

   task automatic test_read_zero_wait;
      int lat;
      PREADY = 1'b1; PRDATA = 16'h0003;
      issue(1'b0, 10'h003, 16'h0000);
      lat = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge PCLK); lat++;
         if (i == 0) cmd_valid = 1'b0;
         if (rsp_valid === 1'b1) break;
      end
      checks++;
      if ({lat[7:0], rsp_rdata, rsp_err} !== {8'd3, 16'h0003, 1'b0}) begin
         failures++;
         $display("FAIL rd_zero_wait lat=%0d rdata=%h err=%b exp lat=3 rdata=0003 err=0", lat, rsp_rdata, rsp_err);
      end
      consume;
   endtask

   task automatic test_wait_states;
      PREADY = 1'b0; PRDATA = 16'hDEAD;
      issue(1'b0, 10'h004, 16'h0000);
      @(negedge PCLK);               // N+1 setup
      cmd_valid = 1'b0;
      for (int c = 2; c <= 4; c++) begin
         @(negedge PCLK);            // N+2..N+4 access
         checks++;
         if ({PSEL, PENABLE, rsp_valid, PADDR} !== {3'b110, 10'h004}) begin
            failures++;
            $display("FAIL ws_access_c%0d got=%h exp=%h", c, {PSEL, PENABLE, rsp_valid, PADDR}, {3'b110, 10'h004});
         end
         if (c == 4) begin
            PREADY = 1'b1; PRDATA = 16'h0002;
         end
      end
      @(negedge PCLK);               // N+5
      checks++;
      if ({rsp_valid, rsp_rdata, rsp_err, PADDR} !== {1'b1, 16'h0002, 1'b0, 10'h004}) begin
         failures++;
         $display("FAIL ws_resp got=%h exp=%h", {rsp_valid, rsp_rdata, rsp_err, PADDR}, {1'b1, 16'h0002, 1'b0, 10'h004});
      end
      consume;
   endtask

   task automatic test_timeout;
      int lat, nacc;
      // PREADY stuck low
      PREADY = 1'b0; PRDATA = 16'hBEEF;
      issue(1'b0, 10'h005, 16'h0000);
      lat = 0; nacc = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge PCLK); lat++;
         if (i == 0) cmd_valid = 1'b0;
         if (PENABLE === 1'b1) nacc++;
         if (rsp_valid === 1'b1) break;
      end
      checks++;
      if ({lat[7:0], nacc[7:0], PSEL, PENABLE, rsp_err, rsp_rdata} !== {8'd10, 8'd8, 1'b0, 1'b0, 1'b1, 16'h0000}) begin
         failures++;
         $display("FAIL timeout lat=%0d acc=%0d psel=%b err=%b rdata=%h exp lat=10 acc=8 psel=0 err=1 rdata=0000",
                  lat, nacc, PSEL, rsp_err, rsp_rdata);
      end
      consume;
      // normal read afterwards
      PREADY = 1'b1; PRDATA = 16'h1234;
      issue(1'b0, 10'h006, 16'h0000);
      lat = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge PCLK); lat++;
         if (i == 0) cmd_valid = 1'b0;
         if (rsp_valid === 1'b1) break;
      end
      checks++;
      if ({lat[7:0], rsp_rdata, rsp_err} !== {8'd3, 16'h1234, 1'b0}) begin
         failures++;
         $display("FAIL after_timeout lat=%0d rdata=%h err=%b exp lat=3 rdata=1234 err=0", lat, rsp_rdata, rsp_err);
      end
      consume;
      // PREADY rises on the expiry cycle: completion wins
      PREADY = 1'b0; PRDATA = 16'h0BEE;
      issue(1'b0, 10'h007, 16'h0000);
      lat = 0; nacc = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge PCLK); lat++;
         if (i == 0) cmd_valid = 1'b0;
         if (PENABLE === 1'b1) nacc++;
         if (nacc == 8) PREADY = 1'b1;
         if (rsp_valid === 1'b1) break;
      end
      checks++;
      if ({lat[7:0], rsp_rdata, rsp_err} !== {8'd10, 16'h0BEE, 1'b0}) begin
         failures++;
         $display("FAIL ready_at_expiry lat=%0d rdata=%h err=%b exp lat=10 rdata=0bee err=0", lat, rsp_rdata, rsp_err);
      end
      consume;
      PREADY = 1'b1;
   endtask

   task automatic test_backpressure;
      PREADY = 1'b1; PRDATA = 16'hA5A5;
      issue(1'b0, 10'h002, 16'h0000);
      @(negedge PCLK);
      cmd_valid = 1'b0;
      repeat (2) @(negedge PCLK);    // N+3: response up
      PRDATA = 16'h0000;
      issue(1'b1, 10'h001, 16'h3C3C);
      for (int c = 0; c < 5; c++) begin
         checks++;
         if ({rsp_valid, rsp_rdata, rsp_err, cmd_ready, PSEL} !== {1'b1, 16'hA5A5, 3'b000}) begin
            failures++;
            $display("FAIL bp_hold_c%0d got=%h exp=%h", c, {rsp_valid, rsp_rdata, rsp_err, cmd_ready, PSEL},
                     {1'b1, 16'hA5A5, 3'b000});
         end
         @(negedge PCLK);
      end
      consume;
      checks++;
      if ({rsp_valid, cmd_ready} !== 2'b01) begin
         failures++; $display("FAIL bp_release got=%b exp=01", {rsp_valid, cmd_ready});
      end
      @(negedge PCLK);               // pending write accepted at this edge
      cmd_valid = 1'b0;
      checks++;
      if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA} !== {3'b101, 10'h001, 16'h3C3C}) begin
         failures++;
         $display("FAIL bp_next_setup got=%h exp=%h", {PSEL, PENABLE, PWRITE, PADDR, PWDATA}, {3'b101, 10'h001, 16'h3C3C});
      end
      repeat (2) @(negedge PCLK);
      consume;
   endtask

   task automatic test_reset_mid_access;
      PREADY = 1'b0;
      issue(1'b1, 10'h008, 16'h55AA);
      @(negedge PCLK);
      cmd_valid = 1'b0;
      @(negedge PCLK);               // ACCESS
      checks++;
      if ({PSEL, PENABLE} !== 2'b11) begin
         failures++; $display("FAIL rst_mid_in_access got=%b exp=11", {PSEL, PENABLE});
      end
      PRESET = 1'b1;
      @(negedge PCLK);
      checks++;
      if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err, cmd_ready} !== 48'h0) begin
         failures++;
         $display("FAIL rst_mid_values got=%h exp=000000000000",
                  {PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err, cmd_ready});
      end
      PRESET = 1'b0; PREADY = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge PCLK);
         checks++;
         if ({rsp_valid, PSEL, cmd_ready} !== 3'b001) begin
            failures++; $display("FAIL rst_mid_no_resp_c%0d got=%b exp=001", c, {rsp_valid, PSEL, cmd_ready});
         end
      end
   endtask

   initial begin
      PRESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
      rsp_ready = 1'b0; PRDATA = '0; PREADY = 1'b1;
      test_reset;
      test_write_zero_wait;
      test_read_zero_wait;
      test_wait_states;
      test_timeout;
      test_backpressure;
      test_reset_mid_access;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ssp_apb_master.md
# ssp_apb_master

APB initiator that drives register transfers into the SSP register block (PSEL/PENABLE/PWRITE/PADDR/PWDATA → PRDATA). Accepts one command at a time on a valid/ready command port, runs a two-phase APB transfer with optional wait states and a timeout, and returns read data and error status on a valid/ready response port. It sits between the test/host sequencer (or a CPU-side bridge) and the SSP register block, and is the initiator end of that block's APB slave interface.

## Interface
- TIMEOUT_CYCLES, default 16: maximum ACCESS cycles with PREADY low before the transfer is aborted; 0 disables the timeout.
- PCLK  input  1  clock; all logic on rising edge.
- PRESET  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  command accepted when cmd_valid & cmd_ready.
- cmd_write  input  1  1 = write, 0 = read.
- cmd_addr  input  10  word address [11:2].
- cmd_wdata  input  16  write data.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  response consumed when rsp_valid & rsp_ready.
- rsp_rdata  output  16  read data; 0 for writes and for timeouts.
- rsp_err  output  1  1 = transfer timed out.
- PSEL, PENABLE, PWRITE  output  1 each  APB control.
- PADDR  output  10  [11:2].
- PWDATA  output  16.
- PRDATA  input  16.
- PREADY  input  1  slave ready; tie high for a zero-wait slave.

## Operation
- FSM states are IDLE, SETUP, ACCESS, RESP.
- **IDLE**
  - cmd_ready = 1 only in IDLE with rsp_valid = 0.
  - On accept: latch write, addr and wdata into the PADDR/PWRITE/PWDATA registers, then go to SETUP.
- **SETUP**
  - PSEL = 1, PENABLE = 0.
  - Always goes to ACCESS next cycle.
- **ACCESS**
  - PSEL = 1, PENABLE = 1.
  - PREADY = 1: capture PRDATA into rsp_rdata (force 0 on write), set rsp_err = 0, go to RESP.
  - PREADY = 0: increment the wait counter.
  - Timeout: when the counter reaches TIMEOUT_CYCLES (TIMEOUT_CYCLES ≠ 0), abort with rsp_rdata = 0 and rsp_err = 1, then go to RESP.
- **RESP**
  - PSEL = PENABLE = 0; rsp_valid = 1.
  - Stay in RESP until rsp_ready = 1, then go to IDLE.
  - rsp_rdata and rsp_err are held stable while rsp_valid & !rsp_ready.
- PADDR, PWRITE and PWDATA are held constant from SETUP through the end of ACCESS. Outside a transfer they keep their last value; PWDATA is not zeroed.
- The wait counter clears on entry to SETUP. Its width is clog2(TIMEOUT_CYCLES + 1), minimum 1.
- Simultaneous PREADY = 1 and timeout count reached: the PREADY completion wins and rsp_err = 0.
- **Reset**
  - PRESET = 1 forces IDLE at the next edge; any in-flight command is dropped with no response.
  - Reset values:
    - PSEL = 0, PENABLE = 0, PWRITE = 0, PADDR = 0, PWDATA = 0
    - rsp_valid = 0, rsp_rdata = 0, rsp_err = 0
    - cmd_ready = 0 while PRESET is high, then 1 in the first cycle after release.

## Timing
- Command accepted at edge N, zero-wait slave:
  - SETUP in cycle N+1.
  - ACCESS in cycle N+2; PRDATA sampled at the end of N+2.
  - rsp_valid high in cycle N+3.
- Each PREADY-low cycle adds one cycle of latency.
- Minimum issue interval is 4 cycles: accept → SETUP → ACCESS → RESP (consumed) → IDLE.
- All outputs are registered except cmd_ready, which is decoded from state and rsp_valid.
- PRDATA is sampled only in an ACCESS cycle with PREADY = 1.

## Structure
- Shared package ssp_pkg holds:
  - the FSM state enum;
  - SSP register word-address constants: CR0 0x00, CR1 0x01, DR 0x02, SR 0x03, CPSR 0x04, IMSC 0x05, RIS 0x06, MIS 0x07, DMACR 0x08;
  - a command struct {write, addr, wdata}.
- Sub-module ssp_apb_wdog: loadable wait counter with clear, enable and a `expired` output. It is instanced once; the FSM and datapath stay in the top module.

## Test plan
- **Write, zero-wait:** write 0x00C7 to CR0 (addr 0x00), PREADY = 1.
  - N+1: PSEL = 1, PENABLE = 0, PADDR = 0x00, PWDATA = 0x00C7.
  - N+2: PENABLE = 1.
  - N+3: rsp_valid = 1, rsp_rdata = 0, rsp_err = 0.
- **Read, zero-wait:** read SR (0x03) with PRDATA = 0x0003.
  - Response at N+3 with rsp_rdata = 0x0003, rsp_err = 0.
- **Wait states:** read CPSR (0x04) with PREADY low for 2 ACCESS cycles, PRDATA = 0x0002 when PREADY rises.
  - rsp_valid at N+5, rsp_rdata = 0x0002; PADDR stable throughout.
- **Timeout:** TIMEOUT_CYCLES = 8, PREADY stuck low.
  - After 8 ACCESS cycles: PSEL drops, rsp_err = 1, rsp_rdata = 0.
  - A following read with PREADY = 1 completes normally.
- **Response backpressure:** hold rsp_ready = 0 for 5 cycles after rsp_valid.
  - rsp_rdata and rsp_err stay stable and cmd_ready stays 0, even with cmd_valid = 1.
  - cmd_ready rises the cycle after rsp_ready = 1.
- **Reset mid-ACCESS:** assert PRESET for 1 cycle during ACCESS.
  - Next edge: PSEL = PENABLE = 0, rsp_valid = 0, all outputs at reset values, and no response for the dropped command.
